// File: rtl/rx_hex_word_pkg.sv
// rx_hex_pkg: shared types, character constants and hex helper for rx_hex_word.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package rx_hex_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    ECHO  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CL_HEX   = 3'd0,
    CL_BS    = 3'd1,
    CL_TERM  = 3'd2,
    CL_SPACE = 3'd3,
    CL_BAD   = 3'd4
  } char_class_t;

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_DEL = 8'h7F;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_ERR = 8'h3F;

  // Returns {valid, nibble}; nibble is zero when the byte is not a hex digit.
  function automatic logic [4:0] hex_val(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

endpackage

// File: rtl/rx_hex_word_decode.sv
// hex_char_decode: classifies one ASCII byte as hex digit, backspace, terminator, space or bad.
// Latency: purely combinational.
// Backpressure: none; follows its input every cycle.
module hex_char_decode
  import rx_hex_pkg::*;
(
  input  logic [7:0]  ch,
  output char_class_t cls,
  output logic [3:0]  nibble
);

  logic [4:0] hv;

  assign hv     = hex_val(ch);
  assign nibble = hv[3:0];

  // Priority classification; anything unrecognised is BAD.
  always_comb begin
    cls = CL_BAD;
    if (hv[4])
      cls = CL_HEX;
    else if (ch == CH_BS || ch == CH_DEL)
      cls = CL_BS;
    else if (ch == CH_CR || ch == CH_LF)
      cls = CL_TERM;
    else if (ch == CH_SP)
      cls = CL_SPACE;
  end

endmodule

// File: rtl/rx_hex_word.sv
// rx_hex_word: parses typed ASCII hex (digits, BS/DEL, CR/LF) into a word; echo via RX_HEX_WORD_ECHO_EN.
// Latency: terminator accepted at edge N -> dvld/dout from edge N; echo byte valid the cycle after accept.
// Backpressure: rdy_rx low while a word waits for drdy (and while an echo byte waits for rdy_tx).
module rx_hex_word
  import rx_hex_pkg::*;
#(
  parameter  int MAX_DIGITS = 8,
  localparam int DW         = 4 * MAX_DIGITS
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    d_rx,
  input  logic          vld_rx,
  output logic          rdy_rx,
  output logic [DW-1:0] dout,
  output logic          dvld,
  input  logic          drdy,
  output logic [3:0]    ndig,
  output logic          err,
  output logic [7:0]    d_tx,
  output logic          vld_tx,
  input  logic          rdy_tx
);

  char_class_t   cls;
  logic [3:0]    nib;
  state_t        state, state_nxt;
  logic [DW-1:0] acc;
  logic          accept;
  logic          commit;

  hex_char_decode u_dec (
    .ch     (d_rx),
    .cls    (cls),
    .nibble (nib)
  );

  assign rdy_rx = (state == ACCUM);
  assign accept = vld_rx && rdy_rx;
  // A terminator with no digits held is swallowed, so CR+LF commits only once.
  assign commit = accept && (cls == CL_TERM) && (ndig != 4'd0);

`ifdef RX_HEX_WORD_ECHO_EN
  logic echo_take;
  logic pend_commit;

  assign echo_take = accept && !((cls == CL_TERM) && (ndig == 4'd0));
  assign vld_tx    = (state == ECHO);

  // Capture the echo byte and remember whether it committed a word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_tx        <= 8'h00;
      pend_commit <= 1'b0;
    end else if (echo_take) begin
      pend_commit <= commit;
      case (cls)
        CL_BS:   d_tx <= CH_BS;
        CL_BAD:  d_tx <= CH_ERR;
        default: d_tx <= d_rx;
      endcase
    end
  end
`else
  logic unused_rdy_tx;

  assign unused_rdy_tx = rdy_tx;
  assign vld_tx        = 1'b0;
  assign d_tx          = 8'h00;
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state <= ACCUM;
    else
      state <= state_nxt;
  end

  // Next-state: accept -> (echo) -> hold until the word is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: begin
`ifdef RX_HEX_WORD_ECHO_EN
        if (echo_take) state_nxt = ECHO;
`else
        if (commit) state_nxt = HOLD;
`endif
      end
`ifdef RX_HEX_WORD_ECHO_EN
      ECHO: begin
        if (vld_tx && rdy_tx) state_nxt = pend_commit ? HOLD : ACCUM;
      end
`endif
      // The word may already have been taken while the echo was pending.
      HOLD: begin
        if (!dvld || drdy) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Accumulator, digit count, sticky error and output word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc  <= '0;
      dout <= '0;
      ndig <= 4'd0;
      err  <= 1'b0;
      dvld <= 1'b0;
    end else begin
      if (dvld && drdy) dvld <= 1'b0;
      if (accept) begin
        case (cls)
          CL_HEX: begin
            acc <= {acc[DW-5:0], nib};
            if (ndig != 4'(MAX_DIGITS)) ndig <= ndig + 4'd1;
          end
          CL_BS: begin
            if (ndig != 4'd0) begin
              acc  <= acc >> 4;
              ndig <= ndig - 4'd1;
            end
          end
          CL_TERM: begin
            if (ndig != 4'd0) begin
              dout <= acc;
              dvld <= 1'b1;
              acc  <= '0;
              ndig <= 4'd0;
              err  <= 1'b0;
            end
          end
          CL_SPACE: ;
          default: begin
            acc  <= '0;
            ndig <= 4'd0;
            err  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_hex_word.sv
// tb_rx_hex_word: table vectors, hand sequences and random bytes against a nibble-queue model.
// Latency: n/a.
// Backpressure: drives drdy/rdy_tx stalls to exercise hold behaviour.
module tb_rx_hex_word;

  logic        clk;
  logic        rstn;
  logic [7:0]  d_rx;
  logic        vld_rx;
  logic        rdy_rx;
  logic [31:0] dout;
  logic        dvld;
  logic        drdy;
  logic [3:0]  ndig;
  logic        err;
  logic [7:0]  d_tx;
  logic        vld_tx;
  logic        rdy_tx;

  rx_hex_word dut (
    .clk    (clk),
    .rstn   (rstn),
    .d_rx   (d_rx),
    .vld_rx (vld_rx),
    .rdy_rx (rdy_rx),
    .dout   (dout),
    .dvld   (dvld),
    .drdy   (drdy),
    .ndig   (ndig),
    .err    (err),
    .d_tx   (d_tx),
    .vld_tx (vld_tx),
    .rdy_tx (rdy_tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the digits typed so far, oldest first.
  int unsigned mq[$];
  bit          m_err;
  logic [31:0] exp_q[$];

  function automatic void model_byte(input logic [7:0] b);
    logic [31:0] w;
    if ((b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66)) begin
      if (b <= 8'h39) mq.push_back(int'(b) - 'h30);
      else            mq.push_back(int'(b | 8'h20) - 'h57);
      if (mq.size() > 8) void'(mq.pop_front());
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (mq.size() > 0) void'(mq.pop_back());
    end else if (b == 8'h0D || b == 8'h0A) begin
      if (mq.size() > 0) begin
        w = 0;
        foreach (mq[i]) w = w * 16 + mq[i];
        exp_q.push_back(w);
        mq.delete();
        m_err = 0;
      end
    end else if (b != 8'h20) begin
      mq.delete();
      m_err = 1;
    end
  endfunction

  // Output monitor: checks every transferred word and hold behaviour.
  int          commit_cnt = 0;
  logic [31:0] last_word  = '0;
  logic [31:0] prev_dout  = '0;
  bit          prev_wait  = 0;

  always @(negedge clk) begin
    #2;
    if (!rstn) begin
      prev_wait = 0;
    end else begin
      if (prev_wait) begin
        chk("dvld_held", {31'd0, dvld}, 32'd1);
        chk("dout_stable", dout, prev_dout);
      end
      if (dvld && drdy) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", dout);
        end else begin
          chk("word", dout, exp_q.pop_front());
        end
        last_word = dout;
        commit_cnt++;
      end
      prev_wait = dvld && !drdy;
      prev_dout = dout;
    end
  end

  bit rand_drdy = 0;
  always @(negedge clk) if (rand_drdy) drdy = 1'($urandom_range(0, 1));

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    d_rx   = b;
    vld_rx = 1'b1;
    while (!rdy_rx && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_rx) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout: byte 0x%0h not taken, rdy_rx stayed 0, expected 1", b);
      vld_rx = 1'b0;
      return;
    end
    @(posedge clk);
    model_byte(b);
    @(negedge clk);
    vld_rx = 1'b0;
    chk("ndig", {28'd0, ndig}, mq.size());
    chk("err", {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic send_str(input logic [95:0] txt, input int len);
    for (int i = len - 1; i >= 0; i--) send(txt[8*i +: 8]);
  endtask

  typedef struct {
    logic [95:0] txt;
    int          len;
    logic [31:0] word;
    int          commits;
    logic [3:0]  ndig;
    logic        err;
  } vec_t;

  vec_t vt[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [7:0] b;
    int r;

    vt[0] = '{"1234ABCD\015",   9,  32'h1234ABCD, 1, 4'd0, 1'b0};
    vt[1] = '{"12G5\015",       5,  32'h00000005, 1, 4'd0, 1'b0};
    vt[2] = '{"DEADBEEF12\015", 11, 32'hADBEEF12, 1, 4'd0, 1'b0};
    vt[3] = '{"ABC\010\0107\015\012", 8, 32'h000000A7, 1, 4'd0, 1'b0};
    vt[4] = '{"a f\015",        4,  32'h000000AF, 1, 4'd0, 1'b0};
    vt[5] = '{"\17712\177\015", 5,  32'h00000001, 1, 4'd0, 1'b0};
    vt[6] = '{"ZZ",             2,  32'h00000000, 0, 4'd0, 1'b1};
    vt[7] = '{"\0157\012",      3,  32'h00000007, 1, 4'd0, 1'b0};

    rstn   = 1'b0;
    d_rx   = 8'h00;
    vld_rx = 1'b0;
    drdy   = 1'b1;
    rdy_tx = 1'b1;
    m_err  = 0;
    #1;
    chk("rst_dout", dout, 32'd0);
    chk("rst_dvld", {31'd0, dvld}, 32'd0);
    chk("rst_ndig", {28'd0, ndig}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_vld_tx", {31'd0, vld_tx}, 32'd0);
    chk("rst_d_tx", {24'd0, d_tx}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_rdy_rx", {31'd0, rdy_rx}, 32'd1);

    // Table vectors with the consumer always ready.
    for (int v = 0; v < 8; v++) begin
      c0 = commit_cnt;
      send_str(vt[v].txt, vt[v].len);
      repeat (4) @(negedge clk);
      chk("vec_commits", commit_cnt - c0, vt[v].commits);
      if (vt[v].commits > 0) chk("vec_word", last_word, vt[v].word);
      chk("vec_ndig", {28'd0, ndig}, {28'd0, vt[v].ndig});
      chk("vec_err", {31'd0, err}, {31'd0, vt[v].err});
    end

    // Consumer stalled: the word must be held and rx back-pressured.
    drdy = 1'b0;
    send_str("FF\015", 3);
    fork
      send_str("1\015", 2);
      begin
        repeat (20) begin
          @(negedge clk);
          chk("bp_rdy_rx", {31'd0, rdy_rx}, 32'd0);
          chk("bp_dout", dout, 32'h000000FF);
        end
        drdy = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    chk("bp_second", last_word, 32'h00000001);

    // Asynchronous reset mid-word.
    send_str("12", 2);
    @(negedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("arst_dout", dout, 32'd0);
    chk("arst_dvld", {31'd0, dvld}, 32'd0);
    chk("arst_ndig", {28'd0, ndig}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_vld_tx", {31'd0, vld_tx}, 32'd0);
    mq.delete();
    m_err = 0;
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("arst_rdy_rx", {31'd0, rdy_rx}, 32'd1);
`ifdef RX_HEX_WORD_ECHO_EN
    rdy_tx = 1'b0;
    send(8'h33);
    repeat (5) begin
      @(negedge clk);
      chk("echo_vld", {31'd0, vld_tx}, 32'd1);
      chk("echo_dat", {24'd0, d_tx}, 32'h33);
      chk("echo_rdy_rx", {31'd0, rdy_rx}, 32'd0);
    end
    rdy_tx = 1'b1;
    @(negedge clk);
    chk("echo_done", {31'd0, vld_tx}, 32'd0);
    rdy_tx = 1'b0;
    send(8'h0D);
    repeat (5) begin
      @(negedge clk);
      chk("echo_cr", {24'd0, d_tx}, 32'h0D);
    end
    rdy_tx = 1'b1;
`else
    send_str("3\015", 2);
`endif
    repeat (4) @(negedge clk);
    chk("arst_word", last_word, 32'h00000003);

    // Random bytes with a randomly stalling consumer.
    rand_drdy = 1;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        b = 8'($urandom_range(0, 15));
        b = (b < 10) ? 8'h30 + b : (r[0] ? 8'h37 + b : 8'h57 + b);
      end else if (r < 65) b = r[0] ? 8'h08 : 8'h7F;
      else if (r < 78) b = r[0] ? 8'h0D : 8'h0A;
      else if (r < 85) b = 8'h20;
      else b = 8'($urandom_range(0, 255));
      send(b);
    end
    rand_drdy = 0;
    drdy = 1'b1;
    send(8'h0D);
    for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(negedge clk);
    chk("drain", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
